// File: rtl/sft_pkg.sv
// Shared types and constants for the shift/rotate arbiter slice.
// Shift type codes, the per-port request bundle, and a rotate helper.
package sft_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [2:0] SFT_LSL = 3'd0;
    localparam logic [2:0] SFT_LSR = 3'd1;
    localparam logic [2:0] SFT_ASR = 3'd2;
    localparam logic [2:0] SFT_ROR = 3'd3;
    localparam logic [2:0] SFT_RRX = 3'd4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] amt;
        logic [2:0]    shift_type;
        logic          cin;
    } sft_req_t;

    // A zero amount yields x unchanged because (x << 32) vanishes in 32 bits.
    function automatic logic [DW-1:0] sft_rotr(input logic [DW-1:0] x, input logic [AW-1:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/sft_core.sv
// Combinational 32-bit shift/rotate unit with carry-out.
// Zero amounts and unknown type codes pass the operand and carry-in through.
import sft_pkg::*;

module sft_core (
    input  sft_req_t      i_req,
    output logic [DW-1:0] o_data,
    output logic          o_cout
);

    logic [AW-1:0] w_lsl_idx;
    logic [AW-1:0] w_lsr_idx;
    logic [DW-1:0] w_ror;
    logic [DW-1:0] w_asr;

    // For n in 1..31, (32 - n) and (-n mod 32) are the same bit index.
    assign w_lsl_idx = ~i_req.amt + 5'd1;
    assign w_lsr_idx = i_req.amt - 5'd1;
    assign w_ror     = sft_rotr(i_req.data, i_req.amt);
    assign w_asr     = $unsigned($signed(i_req.data) >>> i_req.amt);

    always_comb begin
        o_data = i_req.data;
        o_cout = i_req.cin;
        if (i_req.shift_type == SFT_RRX) begin
            o_data = {i_req.cin, i_req.data[DW-1:1]};
            o_cout = i_req.data[0];
        end else if (i_req.amt != '0) begin
            case (i_req.shift_type)
                SFT_LSL: begin
                    o_data = i_req.data << i_req.amt;
                    o_cout = i_req.data[w_lsl_idx];
                end
                SFT_LSR: begin
                    o_data = i_req.data >> i_req.amt;
                    o_cout = i_req.data[w_lsr_idx];
                end
                SFT_ASR: begin
                    o_data = w_asr;
                    o_cout = i_req.data[w_lsr_idx];
                end
                SFT_ROR: begin
                    o_data = w_ror;
                    o_cout = w_ror[DW-1];
                end
                default: begin
                    o_data = i_req.data;
                    o_cout = i_req.cin;
                end
            endcase
        end
    end

endmodule

// File: rtl/sft_arbiter.sv
// Two-port round-robin arbiter in front of a shared shift/rotate datapath, one result register.
// Optional grant/conflict counters are built when SFT_ARBITER_STATS_EN is defined.
import sft_pkg::*;

module sft_arbiter (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_req_valid,
    output logic [1:0]    o_req_ready,
    input  logic [DW-1:0] i_req_data0,
    input  logic [AW-1:0] i_req_amt0,
    input  logic [2:0]    i_req_type0,
    input  logic          i_req_cin0,
    input  logic [DW-1:0] i_req_data1,
    input  logic [AW-1:0] i_req_amt1,
    input  logic [2:0]    i_req_type1,
    input  logic          i_req_cin1,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic          o_rsp_id,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_cout
`ifdef SFT_ARBITER_STATS_EN
    ,
    output logic [31:0]   o_stat_gnt0,
    output logic [31:0]   o_stat_gnt1,
    output logic [15:0]   o_stat_conflict
`endif
);

    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_cout;
    logic          r_ptr;

    logic          w_free;
    logic          w_both;
    logic [1:0]    w_gnt;
    logic          w_accept;
    logic          w_sel;
    sft_req_t      w_req0;
    sft_req_t      w_req1;
    sft_req_t      w_req_sel;
    logic [DW-1:0] w_core_data;
    logic          w_core_cout;

    assign w_free = !r_rsp_valid || i_rsp_ready;
    assign w_both = &i_req_valid;

    // Grants are masked during reset so nothing is accepted into a register being cleared.
    always_comb begin
        w_gnt = 2'b00;
        if (!i_rst && w_free) begin
            if (w_both) begin
                w_gnt = r_ptr ? 2'b10 : 2'b01;
            end else begin
                w_gnt = i_req_valid;
            end
        end
    end

    assign o_req_ready = w_gnt;
    assign w_accept    = |w_gnt;
    assign w_sel       = w_gnt[1];

    assign w_req0    = '{data: i_req_data0, amt: i_req_amt0, shift_type: i_req_type0, cin: i_req_cin0};
    assign w_req1    = '{data: i_req_data1, amt: i_req_amt1, shift_type: i_req_type1, cin: i_req_cin1};
    assign w_req_sel = w_sel ? w_req1 : w_req0;

    sft_core u_core (
        .i_req  (w_req_sel),
        .o_data (w_core_data),
        .o_cout (w_core_cout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_cout  <= 1'b0;
            r_ptr       <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_sel;
            r_rsp_data  <= w_core_data;
            r_rsp_cout  <= w_core_cout;
            r_ptr       <= ~w_sel;
        end else if (w_free) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_cout  = r_rsp_cout;

`ifdef SFT_ARBITER_STATS_EN
    logic [31:0] r_stat_gnt0;
    logic [31:0] r_stat_gnt1;
    logic [15:0] r_stat_conflict;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat_gnt0     <= '0;
            r_stat_gnt1     <= '0;
            r_stat_conflict <= '0;
        end else begin
            if (w_gnt[0]) r_stat_gnt0 <= r_stat_gnt0 + 32'd1;
            if (w_gnt[1]) r_stat_gnt1 <= r_stat_gnt1 + 32'd1;
            if (w_both && w_free && (r_stat_conflict != 16'hFFFF)) begin
                r_stat_conflict <= r_stat_conflict + 16'd1;
            end
        end
    end

    assign o_stat_gnt0     = r_stat_gnt0;
    assign o_stat_gnt1     = r_stat_gnt1;
    assign o_stat_conflict = r_stat_conflict;
`endif

endmodule
